// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: valid/ready handshake with a one-entry skid buffer.
// All EX-side outputs come straight from flops; flush turns every held beat into a bubble.
module id_ex_stage #(
   parameter int unsigned INST_W = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RAW    = 3,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] inst_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   input  logic [DATA_W-1:0] op1_i,
   input  logic [DATA_W-1:0] op2_i,
   input  logic [RAW-1:0]    rd_addr_i,
   input  logic              reg_wen_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic [DATA_W-1:0] op1_o,
   output logic [DATA_W-1:0] op2_o,
   output logic [RAW-1:0]    rd_addr_o,
   output logic              reg_wen_o,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [RAW-1:0]    rd;
      logic              wen;
   } beat_t;

   // bit 0 is the main-slot valid, bit 1 the skid-slot valid
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t state_q, state_nx;
   beat_t  main_q, skid_q, in_beat, bubble;
   logic   main_v, skid_v, in_fire, out_fire;
   logic   load_main_in, load_main_skid, clear_main, load_skid, clear_skid;

   assign in_beat = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
                      rd: rd_addr_i, wen: reg_wen_i};
   assign bubble  = '{inst: NOP_INST, addr: '0, op1: '0, op2: '0, rd: '0, wen: 1'b0};

   assign main_v    = state_q[0];
   assign skid_v    = state_q[1];
   assign out_valid = main_v;
   assign in_ready  = ~skid_v & rst;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= EMPTY;
      else      state_q <= state_nx;
   end

   always_comb begin
      state_nx       = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      clear_main     = 1'b0;
      load_skid      = 1'b0;
      clear_skid     = 1'b0;
      if (flush_i) begin
         state_nx   = EMPTY;
         clear_main = 1'b1;
         clear_skid = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_nx     = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  state_nx  = FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nx   = EMPTY;
                  clear_main = 1'b1;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nx       = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_nx   = EMPTY;
               clear_main = 1'b1;
               clear_skid = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= bubble;
         skid_q <= '0;
      end else begin
         if (clear_main)          main_q <= bubble;
         else if (load_main_in)   main_q <= in_beat;
         else if (load_main_skid) main_q <= skid_q;
         if (clear_skid)          skid_q <= '0;
         else if (load_skid)      skid_q <= in_beat;
      end
   end

   assign inst_o      = main_q.inst;
   assign inst_addr_o = main_q.addr;
   assign op1_o       = main_q.op1;
   assign op2_o       = main_q.op2;
   assign rd_addr_o   = main_q.rd;
   assign reg_wen_o   = main_q.wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle vector table plus reset and width-sweep sequences.
module tb_id_ex_stage;

   localparam logic [15:0] NOP = 16'hC00C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush_i, in_valid, in_ready, out_valid, out_ready, reg_wen_i, reg_wen_o;
   logic [15:0] inst_i, inst_o, op1_i, op1_o, op2_i, op2_o;
   logic [3:0]  inst_addr_i, inst_addr_o;
   logic [2:0]  rd_addr_i, rd_addr_o;
   logic [1:0]  occupancy;

   logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_wen_i, w_wen_o;
   logic [15:0] w_inst_i, w_inst_o;
   logic [3:0]  w_addr_i, w_addr_o;
   logic [31:0] w_op1_i, w_op1_o, w_op2_i, w_op2_o;
   logic [4:0]  w_rd_i, w_rd_o;
   logic [1:0]  w_occ;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.INST_W(16), .ADDR_W(4), .DATA_W(16), .RAW(3), .NOP_INST(NOP)) u_dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
      .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i), .out_valid(out_valid),
      .out_ready(out_ready), .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o),
      .op2_o(op2_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .occupancy(occupancy)
   );

   id_ex_stage #(.INST_W(16), .ADDR_W(4), .DATA_W(32), .RAW(5), .NOP_INST(NOP)) u_dut32 (
      .clk(clk), .rst(rst), .flush_i(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .inst_i(w_inst_i), .inst_addr_i(w_addr_i), .op1_i(w_op1_i), .op2_i(w_op2_i),
      .rd_addr_i(w_rd_i), .reg_wen_i(w_wen_i), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .inst_o(w_inst_o), .inst_addr_o(w_addr_o), .op1_o(w_op1_o),
      .op2_o(w_op2_o), .rd_addr_o(w_rd_o), .reg_wen_o(w_wen_o), .occupancy(w_occ)
   );

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [15:0] inst;
      logic        ev;
      logic [15:0] einst;
      logic [1:0]  eocc;
      logic        eir;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // every side-band field is a fixed function of the instruction word
   task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [15:0] inst);
      in_valid    = iv;
      out_ready   = ordy;
      flush_i     = fl;
      inst_i      = inst;
      inst_addr_i = inst[3:0];
      op1_i       = ~inst;
      op2_i       = {inst[7:0], inst[15:8]};
      rd_addr_i   = inst[6:4];
      reg_wen_i   = inst[0];
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [15:0] einst);
      logic [15:0] ei, e1, e2;
      logic [3:0]  ea;
      logic [2:0]  er;
      logic        ew;
      ei = ev ? einst : NOP;
      ea = ev ? einst[3:0] : 4'h0;
      e1 = ev ? ~einst : 16'h0;
      e2 = ev ? {einst[7:0], einst[15:8]} : 16'h0;
      er = ev ? einst[6:4] : 3'h0;
      ew = ev ? einst[0] : 1'b0;
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      chk({tag, ".inst_o"}, 64'(inst_o), 64'(ei));
      chk({tag, ".inst_addr_o"}, 64'(inst_addr_o), 64'(ea));
      chk({tag, ".op1_o"}, 64'(op1_o), 64'(e1));
      chk({tag, ".op2_o"}, 64'(op2_o), 64'(e2));
      chk({tag, ".rd_addr_o"}, 64'(rd_addr_o), 64'(er));
      chk({tag, ".reg_wen_o"}, 64'(reg_wen_o), 64'(ew));
   endtask

   task automatic add(input logic iv, input logic ordy, input logic fl, input logic [15:0] inst,
                      input logic ev, input logic [15:0] einst, input logic [1:0] eocc,
                      input logic eir);
      vec_t v;
      v = '{iv: iv, ordy: ordy, fl: fl, inst: inst, ev: ev, einst: einst, eocc: eocc, eir: eir};
      vecs.push_back(v);
   endtask

   initial begin
      // streaming at full throughput
      add(1, 1, 0, 16'h1234, 1, 16'h1234, 2'd1, 1);
      add(1, 1, 0, 16'h5678, 1, 16'h5678, 2'd1, 1);
      add(1, 1, 0, 16'h9ABC, 1, 16'h9ABC, 2'd1, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
      // back-pressure, C (3333) waits until in_ready returns
      add(1, 0, 0, 16'h1111, 1, 16'h1111, 2'd1, 1);
      add(1, 0, 0, 16'h2222, 1, 16'h1111, 2'd2, 0);
      add(1, 0, 0, 16'h3333, 1, 16'h1111, 2'd2, 0);
      add(1, 1, 0, 16'h3333, 1, 16'h2222, 2'd1, 1);
      add(1, 1, 0, 16'h3333, 1, 16'h3333, 2'd1, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
      // flush while FULL with a beat offered
      add(1, 0, 0, 16'h4444, 1, 16'h4444, 2'd1, 1);
      add(1, 0, 0, 16'h5555, 1, 16'h4444, 2'd2, 0);
      add(1, 0, 1, 16'h6666, 0, 16'h0000, 2'd0, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
      // flush in ONE with in_fire and out_fire together
      add(1, 1, 0, 16'h7777, 1, 16'h7777, 2'd1, 1);
      add(1, 1, 1, 16'h8888, 0, 16'h0000, 2'd0, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
      // drain to empty: rd=5, wen=1 beat
      add(1, 0, 0, 16'h0051, 1, 16'h0051, 2'd1, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
      // hold in ONE, refill, then fill and drain
      add(1, 0, 0, 16'h00A3, 1, 16'h00A3, 2'd1, 1);
      add(0, 0, 0, 16'h0000, 1, 16'h00A3, 2'd1, 1);
      add(1, 1, 0, 16'h00B5, 1, 16'h00B5, 2'd1, 1);
      add(0, 0, 0, 16'h0000, 1, 16'h00B5, 2'd1, 1);
      add(1, 0, 0, 16'h00C7, 1, 16'h00B5, 2'd2, 0);
      add(0, 1, 0, 16'h0000, 1, 16'h00C7, 2'd1, 1);
      add(0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);

      drive(1, 0, 0, 16'hFFFF);
      w_flush = 0; w_in_valid = 0; w_out_ready = 0; w_inst_i = '0; w_addr_i = '0;
      w_op1_i = '0; w_op2_i = '0; w_rd_i = '0; w_wen_i = 0;

      // reset held with in_valid=1
      #12;
      chk("rst.in_ready", 64'(in_ready), 64'(0));
      chk("rst.occupancy", 64'(occupancy), 64'(0));
      chk_out("rst", 0, 16'h0);
      rst = 1'b1;
      #1;
      chk("rst_rel.in_ready", 64'(in_ready), 64'(1));

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].inst);
         @(posedge clk);
         #1;
         chk_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].einst);
         chk($sformatf("v%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
         chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].eir));
      end

      // reset mid-transfer drops both held beats
      drive(1, 0, 0, 16'hD1D1);
      @(posedge clk); #1;
      drive(1, 0, 0, 16'hD2D2);
      @(posedge clk); #1;
      chk("mid.occ_full", 64'(occupancy), 64'(2));
      #2 rst = 1'b0;
      #1;
      chk("mid.occupancy", 64'(occupancy), 64'(0));
      chk("mid.in_ready", 64'(in_ready), 64'(0));
      chk_out("mid", 0, 16'h0);
      drive(0, 1, 0, 16'h0000);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk_out("mid_after", 0, 16'h0);
      chk("mid_after.occupancy", 64'(occupancy), 64'(0));

      // 32-bit operand, 5-bit register address instance
      w_in_valid = 1; w_out_ready = 1; w_inst_i = 16'h4321; w_addr_i = 4'hA;
      w_op1_i = 32'hDEADBEEF; w_op2_i = 32'h0BADF00D; w_rd_i = 5'd31; w_wen_i = 1;
      @(posedge clk); #1;
      w_in_valid = 0;
      chk("w.out_valid", 64'(w_out_valid), 64'(1));
      chk("w.inst_o", 64'(w_inst_o), 64'(16'h4321));
      chk("w.inst_addr_o", 64'(w_addr_o), 64'(4'hA));
      chk("w.op1_o", 64'(w_op1_o), 64'(32'hDEADBEEF));
      chk("w.op2_o", 64'(w_op2_o), 64'(32'h0BADF00D));
      chk("w.rd_addr_o", 64'(w_rd_o), 64'(5'd31));
      chk("w.reg_wen_o", 64'(w_wen_o), 64'(1));
      @(posedge clk); #1;
      chk("w.drain_valid", 64'(w_out_valid), 64'(0));
      chk("w.drain_op1", 64'(w_op1_o), 64'(0));
      chk("w.drain_rd", 64'(w_rd_o), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised ID/EX pipeline boundary for the 16-bit core. It replaces the fixed-width flush-only register with a valid/ready handshake and a one-entry skid buffer, so EX back-pressure stalls decode without a combinational ready path.
- Carries instruction, instruction address, two operands, destination register address and write enable.
- A controller flush (taken jump) converts all in-flight contents to bubbles.

Parameters:
- INST_W, 16, instruction width.
- ADDR_W, 4, instruction address width.
- DATA_W, 16, operand width.
- RAW, 3, register-file address width.
- NOP_INST, ISA NOP encoding from the global defines, instruction value driven for a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- flush_i  in  1  synchronous flush from ctrl (jump_en).
- in_valid  in  1  ID presents a beat.
- in_ready  out  1  stage can accept a beat.
- inst_i  in  INST_W  instruction.
- inst_addr_i  in  ADDR_W  instruction address.
- op1_i  in  DATA_W  operand 1.
- op2_i  in  DATA_W  operand 2.
- rd_addr_i  in  RAW  destination register.
- reg_wen_i  in  1  register write enable.
- out_valid  out  1  EX-side beat valid.
- out_ready  in  1  EX accepts the beat.
- inst_o  out  INST_W  instruction, or NOP_INST when invalid.
- inst_addr_o  out  ADDR_W  address, or 0 when invalid.
- op1_o  out  DATA_W  operand 1, or 0 when invalid.
- op2_o  out  DATA_W  operand 2, or 0 when invalid.
- rd_addr_o  out  RAW  destination, or 0 when invalid.
- reg_wen_o  out  1  write enable, forced 0 when invalid.
- occupancy  out  2  number of beats held (0..2).

Behaviour:
- Storage: main slot (drives all outputs directly from flops) and skid slot; each has a valid bit.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Status signals:
  - out_valid = main valid.
  - in_ready = ~skid valid, and is forced 0 while rst is low.
  - occupancy = main valid + skid valid.
- Reset (rst low, asynchronous):
  - both valids 0;
  - inst_o=NOP_INST; inst_addr_o, op1_o, op2_o, rd_addr_o = 0; reg_wen_o=0; occupancy=0.
  - After rst deasserts, in_ready is 1 in the same cycle.
  - Reset mid-transfer drops all held beats.
- State EMPTY (occupancy 0):
  - in_fire -> ONE, main <= inputs.
  - Latency: 1 cycle, beat visible at outputs on the next edge.
- State ONE:
  - in_fire & out_fire -> ONE, main <= inputs. This gives full throughput of 1 beat/cycle.
  - in_fire & ~out_fire -> FULL, skid <= inputs.
  - ~in_fire & out_fire -> EMPTY, main cleared to bubble.
  - Otherwise hold.
- State FULL (in_ready=0):
  - out_fire -> ONE, main <= skid, skid valid <= 0.
  - Otherwise hold.
- Ordering is strictly FIFO; no beat is ever duplicated or reordered.
- Bubble rule: whenever the main slot becomes invalid, its payload flops load NOP_INST/0/0/0/0/0. Outputs are therefore never stale and reg_wen_o is never 1 with out_valid 0.
- Skid payload is don't-care when invalid, but is zeroed on reset and flush.
- Flush (flush_i=1 at an edge) has the highest priority:
  - both slots invalid, outputs bubble, occupancy 0 next cycle;
  - any beat offered that cycle is discarded even if in_fire;
  - a concurrent out_fire is still considered consumed by EX.
- Simultaneous flush and reset: reset dominates.
- Output timing: no combinational path from any input to any output except rst -> in_ready.

Test Plan:
- Reset: hold rst low with in_valid=1 -> in_ready=0, out_valid=0, inst_o=NOP_INST, reg_wen_o=0, occupancy=0. After release, in_ready=1.
- Streaming: out_ready=1, send inst 16'h1234/16'h5678/16'h9ABC on consecutive cycles -> each appears one cycle later at inst_o, back-to-back, occupancy stays 1, in_ready stays 1.
- Back-pressure: out_ready=0, send A=16'h1111, B=16'h2222 -> occupancy 2, in_ready=0, inst_o=A held. Raise out_ready -> A, then B, in order; C offered during the stall is not accepted until in_ready=1.
- Flush in FULL: occupancy 2, assert flush_i one cycle with in_valid=1 -> next cycle out_valid=0, inst_o=NOP_INST, reg_wen_o=0, occupancy=0; the offered beat never appears.
- Drain to empty: single beat with reg_wen_i=1, rd_addr_i=3'd5, consumed -> next cycle out_valid=0, rd_addr_o=0, reg_wen_o=0.
- Parameter sweep: DATA_W=32, RAW=5; op1_i=32'hDEADBEEF, rd_addr_i=5'd31 -> passed through unchanged after 1 cycle.
